seg7_scan_controller: RTL

//   Time-multiplexed scan controller for the 8-digit common-anode 7-segment display.

---
 rtl/seg7_scan_controller.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment display.
// Frame-synchronous shadow registers keep display updates tear-free.
module seg7_scan_controller #(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned DIGIT_TICKS = 100000,
  parameter int unsigned GUARD_TICKS = 1000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [31:0] value_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  en_mask,
  input  logic        lz_blank,
  input  logic        load,
  output logic        load_ack,
  output logic        frame_start,
  output logic [7:0]  AN,
  output logic [6:0]  sseg,
  output logic        DP
);

  localparam int unsigned PRESC_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned MAX_DIG = 8;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIGIT_TICKS - 1);
  localparam logic [PRESC_W-1:0] GUARD_END  = PRESC_W'(GUARD_TICKS);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // Elaboration-time parameter sanity
  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIG) begin : g_bad_digits
    $error("seg7_scan_controller: NUM_DIGITS must be 1..8");
  end
  if (GUARD_TICKS >= DIGIT_TICKS) begin : g_bad_guard
    $error("seg7_scan_controller: GUARD_TICKS must be < DIGIT_TICKS");
  end

  // Hex nibble to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] enc(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // Reset is asserted asynchronously and released synchronously
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  logic [PRESC_W-1:0] presc, presc_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [31:0]        value_sh, value_sh_d;
  logic [7:0]         dp_sh, dp_sh_d;
  logic [7:0]         en_sh, en_sh_d;
  logic               pending, pending_d;
  logic               load_ack_d, frame_start_d;
  logic [7:0]         an_d;
  logic [6:0]         sseg_d;
  logic               dp_d;

  logic               slot_wrap_c;
  logic               frame_wrap_c;
  logic               capture_c;
  logic               guard_c;
  logic               visible_c;
  logic [3:0]         nib_c;
  logic [MAX_DIG-1:0] upper_zero_c;
  logic               zero_acc;

  assign slot_wrap_c  = (presc == PRESC_LAST);
  assign frame_wrap_c = slot_wrap_c && (idx == IDX_LAST);
  assign capture_c    = frame_wrap_c && (pending || load);
  assign guard_c      = (presc < GUARD_END);
  assign nib_c        = value_sh[{idx, 2'b00} +: 4];

  // upper_zero_c[k]: every shadow nibble from k up to the top digit is zero
  always_comb begin
    upper_zero_c = '1;
    zero_acc     = 1'b1;
    for (int k = int'(MAX_DIG) - 1; k >= 0; k--) begin
      if (k < int'(NUM_DIGITS)) begin
        zero_acc = zero_acc & (value_sh[4*k +: 4] == 4'h0);
      end
      upper_zero_c[k] = zero_acc;
    end
  end

  // Digit 0 is never zero-suppressed so a zero value still shows "0"
  assign visible_c = en_sh[idx] && !(lz_blank && (idx != '0) && upper_zero_c[idx]);

  // Next-state: scan counters, load handshake, shadow capture, slot outputs
  always_comb begin
    presc_d       = presc + PRESC_W'(1);
    idx_d         = idx;
    value_sh_d    = value_sh;
    dp_sh_d       = dp_sh;
    en_sh_d       = en_sh;
    pending_d     = pending || load;
    load_ack_d    = 1'b0;
    frame_start_d = frame_wrap_c;
    an_d          = 8'hFF;
    sseg_d        = 7'h7F;
    dp_d          = 1'b1;

    if (slot_wrap_c) begin
      presc_d = '0;
      idx_d   = frame_wrap_c ? '0 : idx + IDX_W'(1);
    end

    if (capture_c) begin
      value_sh_d = value_in;
      dp_sh_d    = dp_in;
      en_sh_d    = en_mask;
      pending_d  = 1'b0;
      load_ack_d = 1'b1;
    end

    if (!guard_c && visible_c) begin
      an_d   = ~(8'b1 << idx);
      sseg_d = enc(nib_c);
      dp_d   = ~dp_sh[idx];
    end
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      idx         <= '0;
      value_sh    <= '0;
      dp_sh       <= '0;
      en_sh       <= '0;
      pending     <= 1'b0;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
      AN          <= 8'hFF;
      sseg        <= 7'h7F;
      DP          <= 1'b1;
    end else begin
      presc       <= presc_d;
      idx         <= idx_d;
      value_sh    <= value_sh_d;
      dp_sh       <= dp_sh_d;
      en_sh       <= en_sh_d;
      pending     <= pending_d;
      load_ack    <= load_ack_d;
      frame_start <= frame_start_d;
      AN          <= an_d;
      sseg        <= sseg_d;
      DP          <= dp_d;
    end
  end

endmodule
